// File: rtl/vid_aud_pkg.sv
// Shared definitions for the vid_aud_tx PLL reconfiguration path.
// MD opcodes, host command encodings and controller FSM states.
package vid_aud_pkg;

    localparam logic [1:0] MD_NOP  = 2'b00;
    localparam logic [1:0] MD_WR   = 2'b01;
    localparam logic [1:0] MD_RD   = 2'b10;
    localparam logic [1:0] MD_ADDR = 2'b11;

    localparam logic [1:0] CMD_WR     = 2'b00;
    localparam logic [1:0] CMD_RD     = 2'b01;
    localparam logic [1:0] CMD_COMMIT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_RESP,
        ST_RST,
        ST_LOCK_WAIT
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, resets to 0.
// Used to bring the asynchronous PLL lock into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_mdrp_ctrl.sv
// MD-port initiator for the PLLA wrapper: register write/read and commit.
// Outputs are registered from the action of the current state.
module pll_mdrp_ctrl
    import vid_aud_pkg::*;
#(
    parameter int RD_LAT       = 2,
    parameter int RST_CYC      = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_cmd,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       resp_err,
    output logic [1:0] md_opc,
    output logic       md_ainc,
    output logic [7:0] md_wdi,
    input  logic [7:0] md_rdo,
    output logic       pll_reset,
    input  logic       pll_lock,
    output logic       busy
);

    localparam int CNT_MAX = (RST_CYC > RD_LAT) ? RST_CYC : RD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int STB_W   = $clog2(LOCK_STABLE + 1);
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_n;

    logic [CNT_W-1:0] r_cnt,        w_cnt_n;
    logic [STB_W-1:0] r_stb,        w_stb_n;
    logic [TMO_W-1:0] r_tmo,        w_tmo_n;
    logic             r_err,        w_err_n;
    logic [7:0]       r_rdata,      w_rdata_n;
    logic [7:0]       r_addr,       w_addr_n;
    logic [7:0]       r_wdata,      w_wdata_n;
    logic             r_is_rd,      w_is_rd_n;
    logic             r_cache_vld,  w_cvld_n;
    logic [7:0]       r_cache_addr, w_caddr_n;

    logic             r_req_ready;
    logic             r_busy;
    logic             r_resp_valid, w_rv_n;
    logic [7:0]       r_resp_rdata, w_rrd_n;
    logic             r_resp_err,   w_rerr_n;
    logic [1:0]       r_md_opc,     w_opc_n;
    logic [7:0]       r_md_wdi,     w_wdi_n;
    logic             r_pll_reset,  w_prst_n;

    logic             w_lock;
    logic             w_accept;
    logic             w_miss;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (pll_lock),
        .o_q   (w_lock)
    );

    assign w_accept = req_valid & r_req_ready;
    assign w_miss   = ~r_cache_vld | (r_cache_addr != req_addr);

    // next-state and next-output decode
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_stb_n   = r_stb;
        w_tmo_n   = r_tmo;
        w_err_n   = r_err;
        w_rdata_n = r_rdata;
        w_addr_n  = r_addr;
        w_wdata_n = r_wdata;
        w_is_rd_n = r_is_rd;
        w_cvld_n  = r_cache_vld;
        w_caddr_n = r_cache_addr;
        w_opc_n   = MD_NOP;
        w_wdi_n   = 8'h00;
        w_prst_n  = 1'b0;
        w_rv_n    = 1'b0;
        w_rerr_n  = 1'b0;
        w_rrd_n   = 8'h00;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_addr_n  = req_addr;
                    w_wdata_n = req_wdata;
                    w_is_rd_n = (req_cmd == CMD_RD);
                    w_err_n   = 1'b0;
                    w_rdata_n = 8'h00;
                    w_cnt_n   = '0;
                    case (req_cmd)
                        CMD_WR, CMD_RD: begin
                            if (w_miss)
                                w_state_n = ST_ADDR;
                            else if (req_cmd == CMD_RD)
                                w_state_n = ST_RD;
                            else
                                w_state_n = ST_WR;
                        end
                        CMD_COMMIT: begin
                            // PLL reset clears its address register
                            w_cvld_n  = 1'b0;
                            w_state_n = ST_RST;
                        end
                        default: begin
                            w_err_n   = 1'b1;
                            w_state_n = ST_RESP;
                        end
                    endcase
                end
            end
            ST_ADDR: begin
                w_opc_n   = MD_ADDR;
                w_wdi_n   = r_addr;
                w_caddr_n = r_addr;
                w_cvld_n  = 1'b1;
                w_state_n = r_is_rd ? ST_RD : ST_WR;
            end
            ST_WR: begin
                w_opc_n   = MD_WR;
                w_wdi_n   = r_wdata;
                w_state_n = ST_RESP;
            end
            ST_RD: begin
                w_opc_n   = MD_RD;
                w_cnt_n   = '0;
                w_state_n = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (r_cnt == RD_LAST) begin
                    w_rdata_n = md_rdo;
                    w_state_n = ST_RESP;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_rv_n    = 1'b1;
                w_rerr_n  = r_err;
                w_rrd_n   = r_rdata;
                w_state_n = ST_IDLE;
            end
            ST_RST: begin
                w_prst_n = 1'b1;
                if (r_cnt == RST_LAST) begin
                    w_stb_n   = '0;
                    w_tmo_n   = '0;
                    w_state_n = ST_LOCK_WAIT;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            ST_LOCK_WAIT: begin
                w_stb_n = w_lock ? (r_stb + STB_W'(1)) : '0;
                w_tmo_n = r_tmo + TMO_W'(1);
                // a lock that becomes stable on the timeout cycle still counts
                if (w_lock && (r_stb == STB_LAST)) begin
                    w_err_n   = 1'b0;
                    w_state_n = ST_RESP;
                end else if (r_tmo == TMO_LAST) begin
                    w_err_n   = 1'b1;
                    w_state_n = ST_RESP;
                end
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_n;
    end

    // datapath, address cache and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_stb        <= '0;
            r_tmo        <= '0;
            r_err        <= 1'b0;
            r_rdata      <= 8'h00;
            r_addr       <= 8'h00;
            r_wdata      <= 8'h00;
            r_is_rd      <= 1'b0;
            r_cache_vld  <= 1'b0;
            r_cache_addr <= 8'h00;
            r_req_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 8'h00;
            r_resp_err   <= 1'b0;
            r_md_opc     <= MD_NOP;
            r_md_wdi     <= 8'h00;
            r_pll_reset  <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_n;
            r_stb        <= w_stb_n;
            r_tmo        <= w_tmo_n;
            r_err        <= w_err_n;
            r_rdata      <= w_rdata_n;
            r_addr       <= w_addr_n;
            r_wdata      <= w_wdata_n;
            r_is_rd      <= w_is_rd_n;
            r_cache_vld  <= w_cvld_n;
            r_cache_addr <= w_caddr_n;
            r_req_ready  <= (w_state_n == ST_IDLE);
            r_busy       <= (w_state_n != ST_IDLE);
            r_resp_valid <= w_rv_n;
            r_resp_rdata <= w_rrd_n;
            r_resp_err   <= w_rerr_n;
            r_md_opc     <= w_opc_n;
            r_md_wdi     <= w_wdi_n;
            r_pll_reset  <= w_prst_n;
        end
    end

    assign req_ready  = r_req_ready;
    assign busy       = r_busy;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign md_opc     = r_md_opc;
    assign md_ainc    = 1'b0;
    assign md_wdi     = r_md_wdi;
    assign pll_reset  = r_pll_reset;

endmodule

// File: doc/pll_mdrp_ctrl.md
Name: pll_mdrp_ctrl

Overview:
- Initiator for the PLLA dynamic-reconfiguration (MD) port; the PLL wrapper is the responder.
- Turns single-beat host requests into MDOPC/MDWDI sequences: register write, register read, and commit.
- Commit pulses PLL reset and waits for a stable lock.
- Sits in vid_aud_tx between the control register block and the PLL wrapper. The top drives the PLL mdclk from this block's clk.

Parameters:
- RD_LAT, 2, clk cycles from READ opcode to mdrdo sample.
- RST_CYC, 16, pll_reset high duration in cycles.
- LOCK_STABLE, 64, consecutive synced-lock-high cycles required after reset release.
- LOCK_TIMEOUT, 1000000, max cycles in lock wait before error; counter width is clog2(LOCK_TIMEOUT+1).

Ports:
- clk  in  1  block clock, also used as PLL mdclk.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_cmd  in  2  00 write, 01 read, 10 commit, 11 reserved.
- req_addr  in  8  PLL register address.
- req_wdata  in  8  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  8  read data; 0 for non-read.
- resp_err  out  1  timeout or reserved cmd.
- md_opc  out  2  to PLL mdopc.
- md_ainc  out  1  to PLL mdainc.
- md_wdi  out  8  to PLL mdwdi.
- md_rdo  in  8  from PLL mdrdo.
- pll_reset  out  1  to PLL reset.
- pll_lock  in  1  async PLL lock.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: req_ready 0 during reset, then 1 in IDLE. resp_valid 0, resp_rdata 0, resp_err 0, md_opc 00, md_ainc 0, md_wdi 0, pll_reset 0, busy 0, address cache invalid.
- All outputs are registered.
- MD opcodes: 00 NOP, 01 WRITE, 10 READ, 11 ADDR (loads address from md_wdi). Each opcode is held exactly 1 cycle, then returns to 00. md_ainc is always 0.
- pll_lock passes through a 2-flop synchronizer before use.
- Handshake: a request is accepted on a clk edge with req_valid && req_ready. Inputs are captured at acceptance. One outstanding request at a time. resp_valid pulses 1 cycle, then the FSM returns to IDLE.
- FSM states: IDLE, ADDR, WR, RD, RD_WAIT, RESP, RST, LOCK_WAIT.
- IDLE, write/read accepted: go to ADDR if the cache is invalid or cached addr != req_addr; otherwise go directly to WR or RD.
- ADDR: md_opc=11, md_wdi=addr. Cache is loaded and set valid.
- WR: md_opc=01, md_wdi=wdata, then RESP.
- RD: md_opc=10, then RD_WAIT.
- RD_WAIT: count RD_LAT-1 cycles, then register md_rdo into resp_rdata and go to RESP.
- Commit: RST holds pll_reset=1 for exactly RST_CYC cycles, then LOCK_WAIT.
- LOCK_WAIT: stable counter increments while synced lock=1 and clears to 0 when lock=0. Reaching LOCK_STABLE goes to RESP with err=0. The timeout counter starts on entry; reaching LOCK_TIMEOUT goes to RESP with err=1.
- Simultaneous stable and timeout in the same cycle: success wins.
- Commit invalidates the address cache (PLL reset clears the PLL address register).
- Reserved cmd: no MD activity; RESP with err=1 one cycle after acceptance.
- req_valid while busy is ignored; nothing is queued.
- Reset mid-operation: all state and outputs go to reset values immediately. pll_reset drops to 0. No response is issued for the aborted request.
- Write latency: acceptance edge to resp_valid is 3 cycles with an address cycle, 2 without.

Decomposition:
- Package vid_aud_pkg holds:
  - MD opcode localparams MD_NOP, MD_WR, MD_RD, MD_ADDR.
  - req_cmd encodings CMD_WR, CMD_RD, CMD_COMMIT.
  - FSM state enum.
- One sub-module, sync_2ff (1-bit two-flop synchronizer, reset value 0), used for pll_lock.

Test Plan:
- Write addr 0x05, data 0x12 from reset: md_opc 11/wdi 0x05, then 01/wdi 0x12 on consecutive cycles. resp_valid 3 cycles after acceptance, err=0.
- Repeat write to 0x05 with data 0x34: no ADDR cycle, only 01/0x34. A read of 0x05 then issues 10 with no ADDR. With md_rdo driven 0xA7 at RD_LAT=2, resp_rdata=0xA7.
- Commit with pll_lock rising 10 cycles after reset release: pll_reset high exactly 16 cycles. resp_valid after 10+2+64 cycles, err=0. The next write to 0x05 issues ADDR again.
- Commit with lock toggling every 30 cycles, LOCK_TIMEOUT=500: the stable counter never reaches 64. resp_err=1 at timeout.
- reset asserted in RST state: pll_reset, busy and md_opc go to 0 asynchronously. req_ready=1 after deassertion, and no resp_valid is issued.
- req_cmd=11: resp_err=1, md_opc remains 00 throughout. A req_valid during busy gets no response.
